// File: rtl/result_drain_ser.sv
// Result-matrix drain engine: walks the N x N result-RAM bank tile by tile and
// serialises matrix C row-major as a byte stream over a valid/ready port.
module result_drain_ser #(
    parameter int N         = 2,
    parameter int DW        = 32,
    parameter int AW        = 8,
    parameter int SEGW      = 7,
    parameter int RAM_LAT   = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SEGW-1:0]   a_seg_cnt,
    input  logic [SEGW-1:0]   w_seg_cnt,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     ram_c_addr,
    output logic [N*N-1:0]    ram_c_rden,
    input  logic [N*N*DW-1:0] ram_c_q,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready
);

    localparam int NR = N * N;
    localparam int NB = DW / 8;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int WW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam int PW = (2 * SEGW > AW + 1) ? 2 * SEGW : AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t          state;
    logic [SEGW-1:0] a_lat;
    logic [SEGW-1:0] w_lat;
    logic [SEGW-1:0] ai_cnt;
    logic [SEGW-1:0] wi_cnt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   c_cnt;
    logic [AW-1:0]   base;
    logic [BW-1:0]   byte_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [DW-1:0]   shreg;

    // Next position in the (ai, r, wi, c) walk, used on the last byte of a word.
    logic [SEGW-1:0] ai_nx;
    logic [SEGW-1:0] wi_nx;
    logic [CW-1:0]   r_nx;
    logic [CW-1:0]   c_nx;
    logic [AW-1:0]   base_nx;
    logic            last_elem;
    logic [DW-1:0]   word_sel;
    logic [NR-1:0]   rden_nx;
    logic [PW-1:0]   cnt_prod;
    logic            zero_cnt;
    logic            too_big;
    logic            byte_last;

    assign cnt_prod  = PW'(a_seg_cnt) * PW'(w_seg_cnt);
    assign zero_cnt  = (a_seg_cnt == '0) || (w_seg_cnt == '0);
    assign too_big   = cnt_prod > (PW'(1) << AW);
    assign byte_last = (byte_cnt == BW'(NB - 1));

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        logic c_last, wi_last, r_last, ai_last;
        c_last  = (c_cnt == CW'(N - 1));
        wi_last = (wi_cnt == w_lat - SEGW'(1));
        r_last  = (r_cnt == CW'(N - 1));
        ai_last = (ai_cnt == a_lat - SEGW'(1));

        c_nx    = c_cnt + CW'(1);
        wi_nx   = wi_cnt;
        r_nx    = r_cnt;
        ai_nx   = ai_cnt;
        base_nx = base;
        if (c_last) begin
            c_nx  = '0;
            wi_nx = wi_cnt + SEGW'(1);
            if (wi_last) begin
                wi_nx = '0;
                r_nx  = r_cnt + CW'(1);
                if (r_last) begin
                    r_nx    = '0;
                    ai_nx   = ai_cnt + SEGW'(1);
                    base_nx = base + AW'(w_lat);
                end
            end
        end
        last_elem = c_last && wi_last && r_last && ai_last;
    end

    // Read strobe for the element that follows the current one.
    always_comb begin
        rden_nx = '0;
        for (int i = 0; i < NR; i++) begin
            rden_nx[i] = (i == int'(r_nx) * N + int'(c_nx));
        end
    end

    // Word of the RAM currently addressed, picked by (r, c).
    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NR; i++) begin
            if (i == int'(r_cnt) * N + int'(c_cnt)) begin
                word_sel = ram_c_q[i*DW +: DW];
            end
        end
    end

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign byte_data = shreg[7:0];
        end else begin : g_msb
            assign byte_data = shreg[DW-1 -: 8];
        end
    endgenerate

    // NOTE: state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift register is reset too, so byte_data reads 0 out of reset.
            state      <= S_IDLE;
            a_lat      <= '0;
            w_lat      <= '0;
            ai_cnt     <= '0;
            wi_cnt     <= '0;
            r_cnt      <= '0;
            c_cnt      <= '0;
            base       <= '0;
            byte_cnt   <= '0;
            wait_cnt   <= '0;
            shreg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ram_c_addr <= '0;
            ram_c_rden <= '0;
            byte_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Drop the word in flight; counters are reloaded on the next start.
                state      <= S_IDLE;
                busy       <= 1'b0;
                ram_c_addr <= '0;
                ram_c_rden <= '0;
                byte_valid <= 1'b0;
                byte_cnt   <= '0;
                shreg      <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            a_lat    <= a_seg_cnt;
                            w_lat    <= w_seg_cnt;
                            err      <= 1'b0;
                            ai_cnt   <= '0;
                            wi_cnt   <= '0;
                            r_cnt    <= '0;
                            c_cnt    <= '0;
                            base     <= '0;
                            byte_cnt <= '0;
                            if (zero_cnt) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else if (too_big) begin
                                err   <= 1'b1;
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state      <= S_RD;
                                busy       <= 1'b1;
                                ram_c_addr <= '0;
                                ram_c_rden <= NR'(1);
                            end
                        end
                    end

                    S_RD: begin
                        ram_c_rden <= '0;
                        if (RAM_LAT > 1) begin
                            wait_cnt <= WW'(RAM_LAT - 2);
                            state    <= S_WAIT;
                        end else begin
                            state <= S_LOAD;
                        end
                    end

                    S_WAIT: begin
                        if (wait_cnt == '0) begin
                            state <= S_LOAD;
                        end else begin
                            wait_cnt <= wait_cnt - WW'(1);
                        end
                    end

                    S_LOAD: begin
                        shreg      <= word_sel;
                        ram_c_addr <= '0;
                        byte_cnt   <= '0;
                        byte_valid <= 1'b1;
                        state      <= S_SEND;
                    end

                    S_SEND: begin
                        if (byte_ready) begin
                            if (byte_last) begin
                                byte_valid <= 1'b0;
                                shreg      <= '0;
                                c_cnt      <= c_nx;
                                wi_cnt     <= wi_nx;
                                r_cnt      <= r_nx;
                                ai_cnt     <= ai_nx;
                                base       <= base_nx;
                                if (last_elem) begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    state      <= S_RD;
                                    ram_c_addr <= base_nx + AW'(wi_nx);
                                    ram_c_rden <= rden_nx;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + BW'(1);
                                if (LSB_FIRST != 0) begin
                                    shreg <= shreg >> 8;
                                end else begin
                                    shreg <= shreg << 8;
                                end
                            end
                        end
                    end

                    S_DONE: begin
                        state <= S_IDLE;
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
